fpu_issue: RTL and testbench
============================

FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter TIMEOUT, 64, max cycles in WAIT before the operation is abandoned.
REQ-002 Parameter FIFO_DEPTH, 2, request buffer entries (power of two, >=2).
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rstn  in  1  reset, asynchronous, active-low.
REQ-005 Ports req_valid in 1, req_ready out 1  request handshake from the pipeline.
REQ-006 Ports req_funct in 5, req_x1 in 32, req_x2 in 32, req_rd in 6  FPU op code, operands, destination tag.
REQ-007 Ports resp_valid out 1, resp_ready in 1  result handshake to writeback.
REQ-008 Ports resp_y out 32, resp_rd out 6, resp_err out 1  result, tag, error flag.
REQ-009 Ports fpu_en out 1, fpu_funct out 5, fpu_x1 out 32, fpu_x2 out 32  drive the FPU.
REQ-010 Ports fpu_y in 32, fpu_valid in 1, fpu_idle in 1  FPU result, completion, all-units-idle.
REQ-011 Port busy  out 1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-012 Legal funct: 00001 fadd, 00010 fsub, 00100 fmul, 01000 fdiv, 11000 fsqrt, 10100 itof, 10010 ftoi; every other code is illegal.
REQ-013 Unary ops (fsqrt, itof, ftoi) take their operand from req_x2; req_x1 is forwarded unchanged and is don't-care.
REQ-014 Request accepted when req_valid & req_ready; req_ready = FIFO not full (no same-cycle bypass when full, even if a pop occurs).
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: FIFO head legal -> ISSUE; head illegal -> RESP with resp_y=0, resp_err=1, no fpu_en; FIFO empty -> stay.
REQ-017 ISSUE: fpu_en=1 for exactly one cycle, combinationally when fpu_idle=1, with fpu_funct/x1/x2 = FIFO head; then -> WAIT; fpu_idle=0 -> stay, fpu_en=0.
REQ-018 fpu_funct/x1/x2 SHALL hold the head entry stable from ISSUE through WAIT; 0 in IDLE and RESP.
REQ-019 WAIT: fpu_valid=1 -> capture fpu_y into result register, resp_err=0, -> RESP; fpu_valid sampled only in WAIT.
REQ-020 WAIT cycle counter starts at 0 on entry; reaching TIMEOUT without fpu_valid -> RESP with resp_y=0, resp_err=1.
REQ-021 RESP: resp_valid=1, resp_y/resp_rd/resp_err held stable until resp_ready; on resp_valid & resp_ready, pop FIFO head, -> IDLE.
REQ-022 Minimum latency, legal op, fpu_idle=1, unit latency L: accept cycle 0, IDLE->ISSUE cycle 1, fpu_en cycle 2, resp_valid at cycle 3+L.
REQ-023 Requests complete strictly in acceptance order; at most one op outstanding at the FPU.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL both take effect; occupancy unchanged.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an occupancy count.

Reset
REQ-026 rstn low: FSM=IDLE, FIFO empty, counter=0, result register=0; outputs req_ready=0 while rstn low, then 1.
REQ-027 Outputs under reset: resp_valid=0, resp_y=0, resp_rd=0, resp_err=0, fpu_en=0, fpu_funct/x1/x2=0, busy=0.
REQ-028 Reset mid-operation drops all buffered and in-flight requests; a late fpu_valid after reset is ignored; the next ISSUE waits for fpu_idle.

Structure
REQ-029 Package fpu_pkg holds the seven funct localparams, the FSM state enum, and the request struct {funct, x1, x2, rd}.
REQ-030 Sub-module fpu_req_fifo (parameterised depth, request-struct payload) is instantiated once; the FSM and timeout counter reside in fpu_issue.

Verification
REQ-031 fadd 0x3F800000+0x40000000, rd=5, FPU L=2, resp_ready=1 -> fpu_en one cycle at cycle 2, resp_valid at cycle 5, resp_y=0x40400000, resp_rd=5, err=0.
REQ-032 fsqrt with req_x2=0x40800000, req_x1=0xDEADBEEF -> fpu_x2=0x40800000, fpu_funct=11000, resp_y=0x40000000.
REQ-033 req_funct=10000, rd=7 -> no fpu_en, resp_valid with resp_y=0, resp_err=1, resp_rd=7.
REQ-034 Three back-to-back requests with resp_ready=0 -> req_ready drops after second accept; responses in order once resp_ready=1.
REQ-035 fpu_valid tied 0, TIMEOUT=64 -> resp_err=1, resp_y=0 after exactly 64 WAIT cycles; next request then issues normally.
REQ-036 fpu_idle=0 for 10 cycles in ISSUE, then rstn pulse -> fpu_en never asserted, all outputs at reset values, busy=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue stage: opcodes, FSM states, buffered request format.
package fpu_pkg;

    localparam logic [4:0] FUNCT_FADD  = 5'b00001;
    localparam logic [4:0] FUNCT_FSUB  = 5'b00010;
    localparam logic [4:0] FUNCT_FMUL  = 5'b00100;
    localparam logic [4:0] FUNCT_FDIV  = 5'b01000;
    localparam logic [4:0] FUNCT_FSQRT = 5'b11000;
    localparam logic [4:0] FUNCT_ITOF  = 5'b10100;
    localparam logic [4:0] FUNCT_FTOI  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0]  funct;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [5:0]  rd;
    } fpu_req_t;

    function automatic logic funct_legal(input logic [4:0] funct);
        logic legal;
        case (funct)
            FUNCT_FADD, FUNCT_FSUB, FUNCT_FMUL, FUNCT_FDIV,
            FUNCT_FSQRT, FUNCT_ITOF, FUNCT_FTOI: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request buffer between the pipeline and the issue FSM; occupancy count separates full from empty.
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  fpu_req_t push_data,
    input  logic     pop,
    output fpu_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fpu_req_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // The FSM inspects the head in the same cycle it decides, so the read is asynchronous.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue.sv
// Issue stage: buffers FPU requests, issues one at a time, waits with timeout, returns results in order.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_funct,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    input  logic [5:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_y,
    output logic [5:0]  resp_rd,
    output logic        resp_err,
    output logic        fpu_en,
    output logic [4:0]  fpu_funct,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_valid,
    input  logic        fpu_idle,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  wait_cnt_reg;
    logic [CW-1:0]  wait_cnt_next;
    logic [31:0]    result_reg;
    logic [31:0]    result_next;
    logic           err_reg;
    logic           err_next;

    fpu_req_t       push_data;
    fpu_req_t       head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           drive_fpu;

    assign push_data = '{funct: req_funct, x1: req_x1, x2: req_x2, rd: req_rd};
    assign req_ready = rstn & ~fifo_full;
    assign push      = req_valid & req_ready;

    fpu_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        result_next   = result_reg;
        err_next      = err_reg;
        fpu_en        = 1'b0;
        pop           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (funct_legal(head.funct)) begin
                        state_next = ST_ISSUE;
                    end else begin
                        state_next  = ST_RESP;
                        result_next = '0;
                        err_next    = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (fpu_idle) begin
                    fpu_en        = 1'b1;
                    state_next    = ST_WAIT;
                    wait_cnt_next = '0;
                end
            end
            ST_WAIT: begin
                if (fpu_valid) begin
                    result_next = fpu_y;
                    err_next    = 1'b0;
                    state_next  = ST_RESP;
                end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
                    // Last permitted WAIT cycle elapsed with no completion: abandon the op.
                    result_next = '0;
                    err_next    = 1'b1;
                    state_next  = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            result_reg   <= result_next;
            err_reg      <= err_next;
        end
    end

    // The head entry stays in the FIFO until the response is taken, so it doubles as the operand hold.
    assign drive_fpu  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign fpu_funct  = drive_fpu ? head.funct : '0;
    assign fpu_x1     = drive_fpu ? head.x1    : '0;
    assign fpu_x2     = drive_fpu ? head.x2    : '0;

    assign resp_valid = (state_reg == ST_RESP);
    assign resp_y     = resp_valid ? result_reg : '0;
    assign resp_rd    = resp_valid ? head.rd    : '0;
    assign resp_err   = resp_valid & err_reg;

    assign busy = ~fifo_empty | (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: directed vector table, multi-cycle corner sequences, random traffic vs. a queue model.
module tb_fpu_issue;

    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_funct = '0;
    logic [31:0] req_x1 = '0;
    logic [31:0] req_x2 = '0;
    logic [5:0]  req_rd = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_y;
    logic [5:0]  resp_rd;
    logic        resp_err;
    logic        fpu_en;
    logic [4:0]  fpu_funct;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic [31:0] fpu_y = '0;
    logic        fpu_valid = 1'b0;
    logic        fpu_idle = 1'b1;
    logic        busy;

    always #5 clk = ~clk;

    fpu_issue #(.TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_x1(req_x1), .req_x2(req_x2), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_y(resp_y), .resp_rd(resp_rd), .resp_err(resp_err),
        .fpu_en(fpu_en), .fpu_funct(fpu_funct), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_valid(fpu_valid), .fpu_idle(fpu_idle),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  funct;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [5:0]  rd;
        bit          timeout;
    } exp_t;

    exp_t exp_q[$];
    logic [4:0] legal_codes [7] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11000, 5'b10100, 5'b10010};

    function automatic bit is_legal(input logic [4:0] f);
        foreach (legal_codes[i]) if (legal_codes[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_unary(input logic [4:0] f);
        return (f == 5'b11000) || (f == 5'b10100) || (f == 5'b10010);
    endfunction

    // Stand-in FPU arithmetic; the two real-valued cases give the exact IEEE results.
    function automatic logic [31:0] fpu_fn(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f == 5'b00001 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (f == 5'b11000 && b == 32'h40800000) return 32'h40000000;
        if (is_unary(f)) return {b[15:0], b[31:16]} ^ {27'h0, f} ^ 32'h5A5A0000;
        return (a * 32'h9E3779B1) ^ b ^ {27'h0, f};
    endfunction

    // ---------------- FPU model + per-cycle observation state ----------------
    int          cyc = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_y;
    logic [4:0]  pend_f;
    logic [31:0] pend_x1, pend_x2;
    int          lat = 1;
    bit          valid_en = 1;
    bit          late_valid = 0;
    int          en_count = 0;
    int          en_cycle = -1;
    logic [4:0]  en_funct;
    logic [31:0] en_x1, en_x2;
    int          resp_first_cycle = -1;
    int          resp_done = 0;
    logic [31:0] last_y;
    logic [5:0]  last_rd;
    logic        last_err;
    logic [5:0]  rd_hist[$];
    bit          prev_hold = 0;
    logic [31:0] hold_y;
    logic [5:0]  hold_rd;
    logic        hold_err;
    bit          prev_resp_valid = 0;
    int          acc_count = 0;
    int          legal_pushed = 0;

    task automatic step();
        exp_t e;
        fpu_valid = late_valid;
        late_valid = 0;
        fpu_y = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend = 0;
                if (valid_en) begin
                    fpu_valid = 1'b1;
                    fpu_y = pend_y;
                end
            end
        end
        #1;
        if (rstn) begin
            check("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
            if (fpu_en) begin
                en_count++;
                en_cycle = cyc;
                en_funct = fpu_funct; en_x1 = fpu_x1; en_x2 = fpu_x2;
                check("en_needs_idle", 32'(fpu_idle), 32'd1);
                check("one_outstanding", 32'(pend), 32'd0);
                check("en_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("en_head_legal", 32'(is_legal(exp_q[0].funct)), 32'd1);
                    check("fpu_funct", 32'(fpu_funct), 32'(exp_q[0].funct));
                    check("fpu_x1", fpu_x1, exp_q[0].x1);
                    check("fpu_x2", fpu_x2, exp_q[0].x2);
                end
                pend = 1; pend_cnt = lat;
                pend_y = fpu_fn(fpu_funct, fpu_x1, fpu_x2);
                pend_f = fpu_funct; pend_x1 = fpu_x1; pend_x2 = fpu_x2;
            end else if (pend) begin
                check("wait_funct_stable", 32'(fpu_funct), 32'(pend_f));
                check("wait_x1_stable", fpu_x1, pend_x1);
                check("wait_x2_stable", fpu_x2, pend_x2);
            end
            if (resp_valid) begin
                if (!prev_resp_valid) resp_first_cycle = cyc;
                check("resp_fpu_funct_zero", 32'(fpu_funct), 32'd0);
                check("resp_fpu_x2_zero", fpu_x2, 32'd0);
                if (prev_hold) begin
                    check("hold_y", resp_y, hold_y);
                    check("hold_rd", 32'(resp_rd), 32'(hold_rd));
                    check("hold_err", 32'(resp_err), 32'(hold_err));
                end
                if (resp_ready) begin
                    check("resp_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        if (!is_legal(e.funct) || e.timeout) begin
                            check("resp_y", resp_y, 32'd0);
                            check("resp_err", 32'(resp_err), 32'd1);
                        end else begin
                            check("resp_y", resp_y, fpu_fn(e.funct, e.x1, e.x2));
                            check("resp_err", 32'(resp_err), 32'd0);
                        end
                        check("resp_rd", 32'(resp_rd), 32'(e.rd));
                    end
                    resp_done++;
                    last_y = resp_y; last_rd = resp_rd; last_err = resp_err;
                    rd_hist.push_back(resp_rd);
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    hold_y = resp_y; hold_rd = resp_rd; hold_err = resp_err;
                end
            end else begin
                if (prev_hold) check("resp_held_valid", 32'(resp_valid), 32'd1);
                prev_hold = 0;
            end
            if (req_valid && req_ready) begin
                e.funct = req_funct; e.x1 = req_x1; e.x2 = req_x2; e.rd = req_rd;
                e.timeout = !valid_en;
                exp_q.push_back(e);
                acc_count++;
                if (is_legal(req_funct)) legal_pushed++;
            end
            prev_resp_valid = resp_valid;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_y"}, resp_y, 32'd0);
        check({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_fpu_en"}, 32'(fpu_en), 32'd0);
        check({tag, "_fpu_funct"}, 32'(fpu_funct), 32'd0);
        check({tag, "_fpu_x1"}, fpu_x1, 32'd0);
        check({tag, "_fpu_x2"}, fpu_x2, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        pend = 0; prev_hold = 0; prev_resp_valid = 0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rstn = 1'b1;
        #1;
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    // ---------------- directed single-request table ----------------
    typedef struct {
        string       name;
        logic [4:0]  funct;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [5:0]  rd;
        int          lat;
        int          en_cyc;
        int          resp_cyc;
        logic [31:0] y;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    task automatic run_row(input vec_t v);
        int done0;
        int acc0;
        done0 = resp_done;
        acc0 = acc_count;
        cyc = 0; en_cycle = -1; resp_first_cycle = -1;
        lat = v.lat;
        req_funct = v.funct; req_x1 = v.x1; req_x2 = v.x2; req_rd = v.rd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 200 && resp_done == done0; k++) step();
        check({v.name, "_accepted"}, 32'(acc_count), 32'(acc0 + 1));
        check({v.name, "_done"}, 32'(resp_done), 32'(done0 + 1));
        check({v.name, "_en_cycle"}, 32'(en_cycle), 32'(v.en_cyc));
        check({v.name, "_resp_cycle"}, 32'(resp_first_cycle), 32'(v.resp_cyc));
        check({v.name, "_y"}, last_y, v.y);
        check({v.name, "_rd"}, 32'(last_rd), 32'(v.rd));
        check({v.name, "_err"}, 32'(last_err), 32'(v.err));
        if (v.en_cyc >= 0) begin
            check({v.name, "_en_funct"}, 32'(en_funct), 32'(v.funct));
            check({v.name, "_en_x2"}, en_x2, v.x2);
        end
    endtask

    initial begin
        int acc0, done0, en0, legal0;
        tbl[0] = '{"fadd",   5'b00001, 32'h3F800000, 32'h40000000, 6'd5,  2,  2, 5, 32'h40400000, 1'b0};
        tbl[1] = '{"fsqrt",  5'b11000, 32'hDEADBEEF, 32'h40800000, 6'd9,  3,  2, 6, 32'h40000000, 1'b0};
        tbl[2] = '{"ill10",  5'b10000, 32'h12345678, 32'h9ABCDEF0, 6'd7,  1, -1, 2, 32'h0,        1'b1};
        tbl[3] = '{"fmul",   5'b00100, 32'h40490FDB, 32'h3F000000, 6'd63, 1,  2, 4, 32'h0,        1'b0};
        tbl[4] = '{"ftoi",   5'b10010, 32'h11111111, 32'hC2C80000, 6'd0,  4,  2, 7, 32'h0,        1'b0};
        tbl[5] = '{"ill00",  5'b00000, 32'hFFFFFFFF, 32'h00000001, 6'd33, 1, -1, 2, 32'h0,        1'b1};
        tbl[6] = '{"fdiv",   5'b01000, 32'h40A00000, 32'h40000000, 6'd21, 1,  2, 4, 32'h0,        1'b0};
        tbl[7] = '{"itof",   5'b10100, 32'h0,        32'h00000007, 6'd44, 5,  2, 8, 32'h0,        1'b0};
        tbl[3].y = fpu_fn(tbl[3].funct, tbl[3].x1, tbl[3].x2);
        tbl[4].y = fpu_fn(tbl[4].funct, tbl[4].x1, tbl[4].x2);
        tbl[6].y = fpu_fn(tbl[6].funct, tbl[6].x1, tbl[6].x2);
        tbl[7].y = fpu_fn(tbl[7].funct, tbl[7].x1, tbl[7].x2);

        @(negedge clk);
        do_reset("por");

        resp_ready = 1'b1; fpu_idle = 1'b1; valid_en = 1;
        for (int i = 0; i < 8; i++) run_row(tbl[i]);

        // Three back-to-back requests with writeback stalled.
        resp_ready = 1'b0; lat = 1;
        acc0 = acc_count; done0 = resp_done;
        rd_hist.delete();
        req_valid = 1'b1;
        req_funct = 5'b00001; req_x1 = 32'h1; req_x2 = 32'h2; req_rd = 6'd11; step();
        req_funct = 5'b11111; req_x1 = 32'h3; req_x2 = 32'h4; req_rd = 6'd12; step();
        req_funct = 5'b00010; req_x1 = 32'h5; req_x2 = 32'h6; req_rd = 6'd13;
        #1;
        check("b2b_ready_low", 32'(req_ready), 32'd0);
        for (int k = 0; k < 8; k++) step();
        check("b2b_third_blocked", 32'(acc_count), 32'(acc0 + 2));
        resp_ready = 1'b1;
        for (int k = 0; k < 100 && resp_done < done0 + 3; k++) begin
            if (acc_count == acc0 + 3) req_valid = 1'b0;
            step();
        end
        req_valid = 1'b0;
        check("b2b_done", 32'(resp_done - done0), 32'd3);
        check("b2b_order_n", 32'(rd_hist.size()), 32'd3);
        if (rd_hist.size() == 3) begin
            check("b2b_order0", 32'(rd_hist[0]), 32'd11);
            check("b2b_order1", 32'(rd_hist[1]), 32'd12);
            check("b2b_order2", 32'(rd_hist[2]), 32'd13);
        end

        // Timeout: FPU never completes.
        valid_en = 0; lat = 2;
        done0 = resp_done;
        cyc = 0; en_cycle = -1; resp_first_cycle = -1;
        req_funct = 5'b00100; req_x1 = 32'hAAAA5555; req_x2 = 32'h0F0F0F0F; req_rd = 6'd17;
        req_valid = 1'b1; step(); req_valid = 1'b0;
        for (int k = 0; k < 300 && resp_done == done0; k++) step();
        check("to_done", 32'(resp_done), 32'(done0 + 1));
        check("to_wait_cycles", 32'(resp_first_cycle - en_cycle - 1), 32'(TIMEOUT));
        check("to_y", last_y, 32'd0);
        check("to_err", 32'(last_err), 32'd1);
        check("to_rd", 32'(last_rd), 32'd17);
        valid_en = 1;
        run_row(tbl[0]);

        // FPU busy while in ISSUE, then reset mid-operation.
        fpu_idle = 1'b0;
        en0 = en_count;
        req_funct = 5'b00001; req_x1 = 32'h3F800000; req_x2 = 32'h40000000; req_rd = 6'd3;
        req_valid = 1'b1; step(); req_valid = 1'b0;
        for (int k = 0; k < 11; k++) step();
        #1;
        check("stall_no_en", 32'(en_count), 32'(en0));
        check("stall_busy", 32'(busy), 32'd1);
        do_reset("mid");
        fpu_idle = 1'b1;
        late_valid = 1;
        step(); step();
        #1;
        check("late_resp_valid", 32'(resp_valid), 32'd0);
        check("late_busy", 32'(busy), 32'd0);
        check("late_fpu_en", 32'(fpu_en), 32'd0);
        check("late_en_count", 32'(en_count), 32'(en0));
        run_row(tbl[1]);

        // Random traffic against the queue model.
        en0 = en_count; legal0 = legal_pushed;
        for (int k = 0; k < 3000; k++) begin
            req_valid  = ($urandom_range(0, 9) < 6);
            req_funct  = ($urandom_range(0, 9) < 8) ? legal_codes[$urandom_range(0, 6)] : 5'($urandom);
            req_x1     = $urandom;
            req_x2     = $urandom;
            req_rd     = 6'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            fpu_idle   = !pend && ($urandom_range(0, 3) != 0);
            lat        = $urandom_range(1, 5);
            step();
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        for (int k = 0; k < 500 && (exp_q.size() > 0 || pend); k++) begin
            fpu_idle = !pend;
            step();
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("rand_en_vs_legal", 32'(en_count - en0), 32'(legal_pushed - legal0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
